// File: rtl/gate_pipe.sv
// Pipelined bitwise reducer: NUM_IN words reduced by a selectable operator,
// carried through STAGES valid/ready register stages, with a saturating accept counter.
module gate_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              op_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [15:0]             acc_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]             acc_cnt_q, acc_cnt_d;
  logic [STAGES-1:0]            adv_c;
  logic [WIDTH-1:0]             red_c;
  logic                         accept_c;

  // Reduction across all words; NAND is the inverted AND reduction, not a chain.
  always_comb begin
    red_c = in_data[WIDTH-1:0];
    for (int unsigned i = 1; i < NUM_IN; i++) begin
      case (op_mode)
        OP_AND, OP_NAND: red_c = red_c & in_data[i*WIDTH +: WIDTH];
        OP_OR:           red_c = red_c | in_data[i*WIDTH +: WIDTH];
        default:         red_c = red_c ^ in_data[i*WIDTH +: WIDTH];
      endcase
    end
    if (op_mode == OP_NAND) red_c = ~red_c;
  end

  // Stage k may advance if any slot from k to the output is empty, or the output pops.
  always_comb begin
    adv_c = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      adv_c[k] = out_ready;
      for (int unsigned j = k; j < STAGES; j++) begin
        if (!v_q[j]) adv_c[k] = 1'b1;
      end
    end
  end

  assign in_ready = adv_c[0];
  assign accept_c = in_valid && adv_c[0];

  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    acc_cnt_d = acc_cnt_q;
    if (adv_c[0]) begin
      v_d[0] = accept_c;
      if (accept_c) data_d[0] = red_c;
    end
    // Empty upstream slots leave the downstream data register untouched.
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (adv_c[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) data_d[k] = data_q[k-1];
      end
    end
    if (accept_c && (acc_cnt_q != CNT_MAX)) acc_cnt_d = acc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q       <= '0;
      data_q    <= '0;
      acc_cnt_q <= '0;
    end else begin
      v_q       <= v_d;
      data_q    <= data_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign acc_cnt   = acc_cnt_q;

endmodule

// File: tb/tb_gate_pipe.sv
// Scoreboard bench for gate_pipe: driver pushes reference results, negedge monitor checks outputs.
module tb_gate_pipe;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NUM_IN = 2;
  localparam int unsigned STAGES = 2;
  localparam int unsigned NW     = NUM_IN * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b1;
  logic             in_ready;
  logic [NW-1:0]    in_data = '0;
  logic [1:0]       op_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      acc_cnt;

  gate_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op_mode(op_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: per bit, count the ones across words and apply the operator's rule.
  function automatic logic [WIDTH-1:0] ref_reduce(input logic [NW-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      ones = 0;
      for (int i = 0; i < int'(NUM_IN); i++) ones += int'(d[i*int'(WIDTH)+b]);
      case (m)
        2'b00:   r[b] = (ones == int'(NUM_IN));
        2'b01:   r[b] = (ones > 0);
        2'b10:   r[b] = (ones % 2 == 1);
        default: r[b] = (ones != int'(NUM_IN));
      endcase
    end
    return r;
  endfunction

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } exp_t;

  exp_t        sb_q[$];
  int          exp_cnt = 0;
  logic        last_rst = 1'b1;
  logic        preload_tgl = 1'b0;
  logic        preload_seen = 1'b0;

  // Monitor: compare the state after the last edge, then predict the next edge.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    if (preload_tgl != preload_seen) begin
      preload_seen = preload_tgl;
      exp_cnt = 32'hFFFE;
    end
    exp_valid = (sb_q.size() > 0) && (cyc >= sb_q[0].acc + int'(STAGES) - 1);
    exp_ready = (sb_q.size() < int'(STAGES)) || out_ready;
    if (last_rst) begin
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_acc_cnt", 32'(acc_cnt), 32'd0);
    end
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) chk("out_data", 32'(out_data), 32'(sb_q[0].data));
    chk("acc_cnt", 32'(acc_cnt), 32'(exp_cnt));
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt  = 0;
      last_rst = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (exp_valid && out_ready) void'(sb_q.pop_front());
      if (in_valid && exp_ready) begin
        sb_q.push_back('{data: ref_reduce(in_data, op_mode), acc: cyc + 1});
        if (exp_cnt < 32'hFFFF) exp_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction and hold it until it is taken at an edge.
  task automatic send(input logic [1:0] m, input logic [NW-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    op_mode  = m;
    in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose (cycle %0d)", cyc);
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset held 3 edges with in_valid asserted.
    repeat (3) step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    step();

    // Operator coverage on F0 / 3C.
    for (int m = 0; m < 4; m++) send(2'(m), {8'h3C, 8'hF0});
    repeat (3) step();
    chk("ops_acc_cnt", 32'(acc_cnt), 32'd4);

    // Backpressure: 1..5 with out_ready low after the first accept.
    send(2'b01, {8'd1, 8'd1});
    out_ready = 1'b0;
    send(2'b01, {8'd2, 8'd2});
    in_valid = 1'b1;
    in_data  = {8'd3, 8'd3};
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_data", 32'(out_data), 32'd1);
    end
    step();
    out_ready = 1'b1;
    for (int v = 3; v <= 5; v++) send(2'b01, {8'(v), 8'(v)});
    repeat (4) step();

    // Full pipeline with simultaneous pop and push.
    out_ready = 1'b0;
    send(2'b10, NW'($urandom));
    send(2'b10, NW'($urandom));
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      op_mode  = 2'($urandom);
      in_data  = NW'($urandom);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd1);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Mid-operation reset with two results in flight and in_valid high.
    out_ready = 1'b0;
    send(2'b00, NW'($urandom));
    send(2'b00, NW'($urandom));
    in_valid = 1'b1;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_acc_cnt", 32'(acc_cnt), 32'd0);
    repeat (4) step();

    // Counter saturation via preload at FFFE.
    force dut.acc_cnt_q = 16'hFFFE;
    preload_tgl = ~preload_tgl;
    step();
    release dut.acc_cnt_q;
    repeat (3) send(2'($urandom), NW'($urandom));
    step();
    chk("sat_acc_cnt", 32'(acc_cnt), 32'hFFFF);
    repeat (2) step();

    // Random traffic against the reference model.
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      op_mode   = 2'($urandom);
      in_data   = NW'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("final_sat_cnt", 32'(acc_cnt), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
